// File: rtl/cpu_pipe_state_mt.sv
// Pipeline-stage tracker with per-stage thread tags.
// Drives stage enables, switch pre-warning and thread occupancy.
module cpu_pipe_state_mt #(
  parameter int N_STAGES     = 4,
  parameter int N_THREADS    = 16,
  parameter int ALMOST_STAGE = 1,
  localparam int TW = (N_THREADS > 1) ? $clog2(N_THREADS) : 1
) (
  input  logic                     CLK,
  input  logic                     reset_n,
  input  logic                     reload,
  input  logic [TW-1:0]            reload_thread,
  input  logic                     invalidate,
  input  logic                     flush_en,
  input  logic [TW-1:0]            flush_thread,
  input  logic                     instr_wait,
  output logic [N_STAGES-1:0]      stage_allow,
  output logic [N_STAGES*TW-1:0]   stage_thread,
  output logic                     thread_almost_switched,
  output logic [TW-1:0]            switched_thread,
  output logic [N_THREADS-1:0]     thread_in_pipe,
  output logic                     pipe_empty
);

  localparam int A = ALMOST_STAGE;

  logic [N_STAGES-1:0]  valid;
  logic [N_STAGES-1:0]  valid_d;
  logic [N_STAGES-1:0]  kill;
  logic [N_STAGES-1:0]  src;
  logic [N_STAGES-1:0]  allow_d;
  logic [TW-1:0]        tid   [N_STAGES];
  logic [TW-1:0]        tid_d [N_STAGES];
  logic                 almost_c;
  logic [N_THREADS-1:0] occ;

  always_comb begin
    kill = '0;
    src  = '0;
    for (int i = 0; i < N_STAGES; i++)
      kill[i] = flush_en & valid[i] &
                (tid[i] == flush_thread);
    src[0] = reload | (valid[0] & ~kill[0]);
    for (int i = 1; i < N_STAGES; i++)
      src[i] = valid[i-1] & ~kill[i-1];
    allow_d = (invalidate | instr_wait) ? '0 : src;
  end

  // A reload overrides a stall in stage 0; invalidate overrides both.
  always_comb begin
    valid_d = valid;
    tid_d   = tid;
    if (invalidate) begin
      valid_d = '0;
    end else begin
      if (instr_wait) begin
        valid_d = valid & ~kill;
      end else begin
        valid_d[0] = valid[0] & ~kill[0];
        for (int i = 1; i < N_STAGES; i++) begin
          valid_d[i] = src[i];
          tid_d[i]   = tid[i-1];
        end
      end
      if (reload) begin
        valid_d[0] = 1'b1;
        tid_d[0]   = reload_thread;
      end
    end
  end

  always_comb begin
    almost_c = valid[A] & ~instr_wait & ~invalidate &
               (~valid[A+1] | (tid[A+1] != tid[A]));
  end

  always_comb begin
    occ = '0;
    for (int t = 0; t < N_THREADS; t++)
      for (int i = 0; i < N_STAGES; i++)
        if (valid[i] && tid[i] == TW'(t))
          occ[t] = 1'b1;
  end

  always_comb begin
    stage_thread = '0;
    for (int i = 0; i < N_STAGES; i++)
      stage_thread[i*TW +: TW] = tid[i];
  end

  always_ff @(posedge CLK) begin
    if (!reset_n) begin
      valid <= '0;
      for (int i = 0; i < N_STAGES; i++)
        tid[i] <= '0;
      stage_allow            <= '0;
      thread_almost_switched <= 1'b0;
      switched_thread        <= '0;
      thread_in_pipe         <= '0;
      pipe_empty             <= 1'b1;
    end else begin
      valid <= valid_d;
      for (int i = 0; i < N_STAGES; i++)
        tid[i] <= tid_d[i];
      stage_allow            <= allow_d;
      thread_almost_switched <= almost_c;
      if (almost_c)
        switched_thread <= tid[A];
      thread_in_pipe <= occ;
      pipe_empty     <= ~|valid;
    end
  end

endmodule
